// File: rtl/corevx_membus_arbiter.sv
// corevx_membus_arbiter
//
// Shares one armleobus memory port between two cache lanes.
// Lane 0 is the instruction-fetch cache and lane 1 is the data cache.
// Arbitration is round-robin. A grant is held from request until done.
// A watchdog ends any transaction the slave leaves unfinished for
// TIMEOUT_CYCLES cycles, and returns an ACCESSFAULT for it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_transaction[2]         per-lane request (held until done)
//   m_cmd[2][2]              per-lane command (01 READ, 10 WRITE)
//   m_address[2][ADDR_W]     per-lane address
//   m_wdata[2][32]           per-lane write data
//   m_wbyte_enable[2][4]     per-lane byte enables
//   m_transaction_done[2]    per-lane completion pulse
//   m_transaction_response   per-lane response (00 OK, 11 ACCESSFAULT)
//   m_rdata[2][32]           per-lane read data
//   s_*                      single slave port, routed from lane[grant]
//   timeout_event            one-cycle pulse when the watchdog fires
module corevx_membus_arbiter #(
   parameter int ADDR_W         = 34,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             m_transaction,
   input  logic [1:0][1:0]        m_cmd,
   input  logic [1:0][ADDR_W-1:0] m_address,
   input  logic [1:0][31:0]       m_wdata,
   input  logic [1:0][3:0]        m_wbyte_enable,
   output logic [1:0]             m_transaction_done,
   output logic [1:0][1:0]        m_transaction_response,
   output logic [1:0][31:0]       m_rdata,
   output logic                   s_transaction,
   output logic [1:0]             s_cmd,
   output logic [ADDR_W-1:0]      s_address,
   output logic [31:0]            s_wdata,
   output logic [3:0]             s_wbyte_enable,
   input  logic                   s_transaction_done,
   input  logic [1:0]             s_transaction_response,
   input  logic [31:0]            s_rdata,
   output logic                   timeout_event
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;   // lane 0 wins the first tie
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      grant_d                = grant_q;
      last_grant_d           = last_grant_q;
      cnt_d                  = cnt_q;
      m_transaction_done     = '0;
      m_transaction_response = '0;
      m_rdata                = '0;
      s_transaction          = 1'b0;
      s_cmd                  = '0;
      s_address              = '0;
      s_wdata                = '0;
      s_wbyte_enable         = '0;
      timeout_event          = 1'b0;

      case (state_q)
         IDLE: begin
            if (|m_transaction) begin
               state_d = BUSY;
               cnt_d   = '0;
               // On a tie, take the lane that was not served last.
               // With one requester, the index of the set bit is bit 1.
               grant_d = (&m_transaction) ? ~last_grant_q : m_transaction[1];
            end
         end
         BUSY: begin
            s_transaction                   = m_transaction[grant_q];
            s_cmd                           = m_cmd[grant_q];
            s_address                       = m_address[grant_q];
            s_wdata                         = m_wdata[grant_q];
            s_wbyte_enable                  = m_wbyte_enable[grant_q];
            m_rdata[grant_q]                = s_rdata;
            m_transaction_response[grant_q] = s_transaction_response;

            // The slave's done wins over a watchdog expiring in the same cycle.
            if (s_transaction_done) begin
               m_transaction_done[grant_q] = 1'b1;
               state_d                     = IDLE;
               last_grant_d                = grant_q;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               m_transaction_done[grant_q]     = 1'b1;
               m_transaction_response[grant_q] = 2'b11;
               m_rdata[grant_q]                = '0;
               s_transaction                   = 1'b0;
               timeout_event                   = 1'b1;
               state_d                         = IDLE;
               last_grant_d                    = grant_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_corevx_membus_arbiter.sv
// Directed bench for corevx_membus_arbiter (TIMEOUT_CYCLES = 4).
// The bench acts as the slave and both masters. It drives inputs 1 time unit
// after the rising edge, and it samples outputs on the falling edge.
module tb_corevx_membus_arbiter;

   localparam int AW = 34;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [1:0]          m_transaction = '0;
   logic [1:0][1:0]     m_cmd = '0;
   logic [1:0][AW-1:0]  m_address = '0;
   logic [1:0][31:0]    m_wdata = '0;
   logic [1:0][3:0]     m_wbyte_enable = '0;
   logic [1:0]          m_transaction_done;
   logic [1:0][1:0]     m_transaction_response;
   logic [1:0][31:0]    m_rdata;
   logic                s_transaction;
   logic [1:0]          s_cmd;
   logic [AW-1:0]       s_address;
   logic [31:0]         s_wdata;
   logic [3:0]          s_wbyte_enable;
   logic                s_transaction_done = 1'b0;
   logic [1:0]          s_transaction_response = '0;
   logic [31:0]         s_rdata = '0;
   logic                timeout_event;

   int n_chk  = 0;
   int n_pass = 0;

   corevx_membus_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .m_transaction(m_transaction), .m_cmd(m_cmd), .m_address(m_address),
      .m_wdata(m_wdata), .m_wbyte_enable(m_wbyte_enable),
      .m_transaction_done(m_transaction_done),
      .m_transaction_response(m_transaction_response), .m_rdata(m_rdata),
      .s_transaction(s_transaction), .s_cmd(s_cmd), .s_address(s_address),
      .s_wdata(s_wdata), .s_wbyte_enable(s_wbyte_enable),
      .s_transaction_done(s_transaction_done),
      .s_transaction_response(s_transaction_response), .s_rdata(s_rdata),
      .timeout_event(timeout_event)
   );

   always #5 clk = ~clk;

   // A single done pulse may never reach both lanes.
   assert property (@(posedge clk) disable iff (rst) !(&m_transaction_done));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state
      #2;
      chk("rst_s_trans", s_transaction, 0);
      chk("rst_m_done", m_transaction_done, 0);
      chk("rst_s_addr", s_address, 0);
      step();
      rst = 1'b0;

      // ---------------- single lane 1 READ, done after 3 BUSY cycles
      m_transaction = 2'b10;
      m_cmd[1] = 2'b01;
      m_address[1] = 34'h100;
      @(negedge clk);
      chk("t1_idle_s_trans", s_transaction, 0);
      step();
      @(negedge clk);
      chk("t1_s_trans", s_transaction, 1);
      chk("t1_s_addr", s_address, 34'h100);
      chk("t1_s_cmd", s_cmd, 2'b01);
      step();
      step();
      s_transaction_done = 1'b1;
      s_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_done", m_transaction_done, 2'b10);
      chk("t1_rdata1", m_rdata[1], 32'hDEADBEEF);
      chk("t1_rdata0", m_rdata[0], 0);
      chk("t1_resp1", m_transaction_response[1], 0);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b00;
      @(negedge clk);
      chk("t1_after_done", m_transaction_done, 0);

      // ---------------- tie from reset, then alternate over 8 transactions
      rst = 1'b1;
      m_transaction = 2'b11;
      m_cmd[0] = 2'b01;
      m_address[0] = 34'h1000;
      m_address[1] = 34'h2000;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_idle_gap", i), s_transaction, 0);
         step();
         @(negedge clk);
         chk($sformatf("rr%0d_addr", i), s_address, (i % 2 == 0) ? 34'h1000 : 34'h2000);
         step();
         s_transaction_done = 1'b1;
         @(negedge clk);
         chk($sformatf("rr%0d_done", i), m_transaction_done, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
         s_transaction_done = 1'b0;
      end

      // ---------------- lane 0 WRITE routed while lane 1 waits
      m_cmd[0] = 2'b10;
      m_wdata[0] = 32'h12345678;
      m_wbyte_enable[0] = 4'hF;
      m_address[0] = 34'h2000;
      m_address[1] = 34'h100;
      m_wdata[1] = 32'hFFFF0000;
      m_wbyte_enable[1] = 4'h3;
      s_rdata = 32'h0000_0011;
      @(negedge clk);
      step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("wr_s_wdata", s_wdata, 32'h12345678);
         chk("wr_s_be", s_wbyte_enable, 4'hF);
         chk("wr_s_addr", s_address, 34'h2000);
         chk("wr_s_cmd", s_cmd, 2'b10);
         chk("wr_lane1_rdata", m_rdata[1], 0);
         chk("wr_no_done", m_transaction_done, 0);
         step();
      end
      s_transaction_done = 1'b1;
      @(negedge clk);
      chk("wr_done", m_transaction_done, 2'b01);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b10;

      // ---------------- lane 1 times out (slave silent)
      @(negedge clk);
      step();
      s_rdata = 32'hBAD0BAD0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("to_early_event", timeout_event, 0);
         chk("to_early_done", m_transaction_done, 0);
         step();
      end
      @(negedge clk);
      chk("to_done", m_transaction_done, 2'b10);
      chk("to_resp", m_transaction_response[1], 2'b11);
      chk("to_event", timeout_event, 1);
      chk("to_s_trans", s_transaction, 0);
      chk("to_rdata", m_rdata[1], 0);
      step();
      m_transaction = 2'b01;
      m_cmd[0] = 2'b01;
      m_address[0] = 34'h3000;
      @(negedge clk);
      chk("post_to_idle", s_transaction, 0);
      chk("post_to_event", timeout_event, 0);
      step();
      @(negedge clk);
      chk("post_to_s_trans", s_transaction, 1);
      chk("post_to_addr", s_address, 34'h3000);
      step();
      s_transaction_done = 1'b1;
      s_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("post_to_done", m_transaction_done, 2'b01);
      chk("post_to_rdata", m_rdata[0], 32'hCAFEF00D);
      chk("post_to_resp", m_transaction_response[0], 0);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b10;

      // ---------------- done coincides with counter == TIMEOUT_CYCLES
      @(negedge clk);
      step();
      for (int k = 0; k < 4; k++) step();
      s_transaction_done = 1'b1;
      s_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      chk("edge_done", m_transaction_done, 2'b10);
      chk("edge_resp", m_transaction_response[1], 0);
      chk("edge_event", timeout_event, 0);
      chk("edge_rdata", m_rdata[1], 32'h5A5A5A5A);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b11;

      // ---------------- reset in the middle of BUSY
      @(negedge clk);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_s_trans", s_transaction, 0);
      chk("mid_rst_s_addr", s_address, 0);
      chk("mid_rst_rdata", m_rdata, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_idle", s_transaction, 0);
      step();
      @(negedge clk);
      chk("after_rst_s_trans", s_transaction, 1);
      chk("after_rst_lane0", s_address, 34'h3000);
      step();
      s_transaction_done = 1'b1;
      @(negedge clk);
      chk("after_rst_done", m_transaction_done, 2'b01);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b10;

      // ---------------- granted lane drops its request before done
      @(negedge clk);
      step();
      m_transaction = 2'b01;
      step();
      step();
      @(negedge clk);
      chk("drop_s_trans", s_transaction, 0);
      chk("drop_still_lane1", s_address, 34'h100);
      chk("drop_no_done", m_transaction_done, 0);
      step();
      s_transaction_done = 1'b1;
      @(negedge clk);
      chk("drop_done_lane1", m_transaction_done, 2'b10);
      step();
      s_transaction_done = 1'b0;
      m_transaction = 2'b00;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/corevx_membus_arbiter.md
Name: corevx_membus_arbiter

Overview:
- Shares one armleobus memory port between two cache lanes: lane 0 is the instruction-fetch cache and lane 1 is the data cache.
- Uses round-robin arbitration. A grant is held for the whole transaction, from request until done.
- A watchdog terminates transactions the slave never completes and returns an access-fault response.
- Sits between the two corevx_cache instances and the memory/peripheral interconnect.

Parameters:
- ADDR_W, 34, physical address width.
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for done before it is faulted (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_transaction  in  2  per-lane transaction request
- m_cmd  in  2x2  per-lane command: 01 READ, 10 WRITE
- m_address  in  2xADDR_W  per-lane address
- m_wdata  in  2x32  per-lane write data
- m_wbyte_enable  in  2x4  per-lane byte enables
- m_transaction_done  out  2  per-lane completion pulse
- m_transaction_response  out  2x2  per-lane response: 00 OK, 11 ACCESSFAULT
- m_rdata  out  2x32  per-lane read data
- s_transaction  out  1  slave request
- s_cmd  out  2  slave command
- s_address  out  ADDR_W  slave address
- s_wdata  out  32  slave write data
- s_wbyte_enable  out  4  slave byte enables
- s_transaction_done  in  1  slave completion
- s_transaction_response  in  2  slave response
- s_rdata  in  32  slave read data
- timeout_event  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Bus rule: a master holds m_transaction, cmd, address, wdata and byte enables stable until its done pulse. It may deassert only in the cycle after done.
- States: IDLE, BUSY.
- Registers: grant (1 bit), last_grant (1 bit), and a watchdog counter of clog2(TIMEOUT_CYCLES+1) bits.
- IDLE:
  - No request: stay in IDLE.
  - One lane requesting: grant it.
  - Both lanes requesting: grant the lane != last_grant.
  - On grant: go to BUSY next edge, load the chosen lane into grant, clear the counter.
  - Arbitration latency is therefore 1 cycle.
- BUSY, routing:
  - s_* outputs are combinationally driven from lane[grant].
  - s_transaction = m_transaction[grant].
  - m_rdata[grant] = s_rdata and m_transaction_response[grant] = s_transaction_response.
  - m_transaction_done[grant] = s_transaction_done.
  - The non-granted lane sees done = 0 and rdata/response = 0.
- BUSY, completion:
  - On s_transaction_done: go to IDLE next edge and set last_grant = grant.
  - A new request is not arbitrated in the same cycle as done. There is always one IDLE cycle between transactions.
- BUSY, watchdog:
  - The counter increments every BUSY cycle without done.
  - When the counter == TIMEOUT_CYCLES and done is not present:
    - drive m_transaction_done[grant] = 1 with response 11 and rdata 0;
    - force s_transaction = 0;
    - pulse timeout_event;
    - go to IDLE and set last_grant = grant.
  - If done arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the slave's done and response win and there is no timeout.
- In IDLE all s_* outputs are 0 and all m_* outputs are 0.
- Reset (async, at any time including mid-transaction):
  - state = IDLE, grant = 0, last_grant = 1, so lane 0 wins the first tie;
  - counter = 0, all outputs 0.
  - An in-flight slave transaction is abandoned; the slave must tolerate this.
- Requester dropping out: if m_transaction[grant] deasserts in BUSY before done (a protocol violation), the arbiter stays in BUSY until done or timeout. This is an assertion target in the bench.

Test Plan:
- Single lane 1 READ to 0x0000_0100; slave answers done after 3 cycles with rdata 0xDEADBEEF, resp 00 -> s_transaction rises 1 cycle after request; m_transaction_done[1] pulses with rdata 0xDEADBEEF; lane 0 sees no done.
- Both lanes request from reset; slave answers each in 2 cycles -> lane 0 is served first, then after one IDLE cycle lane 1. Repeated continuous requests alternate 0,1,0,1 over 8 transactions.
- Lane 0 WRITE 0x12345678, byte enables 0xF, address 0x2000 while lane 1 also waits -> s_wdata, s_wbyte_enable and s_address match lane 0 exactly throughout BUSY; lane 1 outputs stay 0.
- TIMEOUT_CYCLES = 4 and the slave never answers -> at the 5th BUSY cycle, m_transaction_done[grant] = 1, response 11, timeout_event = 1 and s_transaction = 0; the next transaction proceeds normally.
- Slave done coincides with the counter reaching TIMEOUT_CYCLES -> response 00 is delivered and timeout_event stays 0.
- Assert rst for 1 cycle in the middle of a BUSY transaction -> all outputs are 0 immediately; after release, simultaneous requests grant lane 0 first.
